// File: rtl/in_conditioner.sv
// in_conditioner
//   Conditions WIDTH raw asynchronous inputs (switches/buttons) for the
//   downstream registered 5-input logic block. Each channel passes through a
//   2-flop synchronizer and a debounce counter. A new level must be seen on
//   the synchronized sample for DB_CYCLES consecutive edges before CLEAN
//   accepts it. Accepted transitions also produce one-cycle edge pulses and
//   advance a saturating event counter.
//
// Ports
//   CLK     in   1      system clock, rising edge
//   RST_N   in   1      asynchronous active-low reset
//   RAW_IN  in   WIDTH  raw asynchronous inputs
//   CLR     in   1      synchronous clear of EVT_CNT
//   CLEAN   out  WIDTH  debounced level; bit0..bit4 feed IN1..IN5 downstream
//   RISE    out  WIDTH  one-cycle pulse on an accepted 0->1 of CLEAN
//   FALL    out  WIDTH  one-cycle pulse on an accepted 1->0 of CLEAN
//   CHG     out  1      OR of RISE|FALL, same cycle
//   EVT_CNT out  EVT_W  saturating count of accepted transitions
module in_conditioner #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3,
  parameter int EVT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] RAW_IN,
  input  logic             CLR,
  output logic [WIDTH-1:0] CLEAN,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             CHG,
  output logic [EVT_W-1:0] EVT_CNT
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = EVT_W + PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p1;
  logic [CNT_W-1:0] cnt_p2 [WIDTH];

  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [PC_W-1:0]  evt_n;
  logic [EVT_W-1:0] evt_nxt;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  // Add without wrapping: any carry above EVT_W bits pins the result at max.
  function automatic logic [EVT_W-1:0] sat_add(input logic [EVT_W-1:0] a,
                                               input logic [PC_W-1:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (|s[SUM_W-1:EVT_W]) begin
      return '1;
    end
    return s[EVT_W-1:0];
  endfunction

  // Debounce decision per channel, from the synchronized sample s2_p1.
  always_comb begin
    clean_nxt = CLEAN;
    rise_nxt  = '0;
    fall_nxt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (s2_p1[i] == CLEAN[i]) begin
        // Sample agrees with the accepted level: any partial attempt is a glitch.
        cnt_nxt[i] = '0;
      end else if (cnt_p2[i] == CNT_LAST) begin
        clean_nxt[i] = s2_p1[i];
        rise_nxt[i]  = s2_p1[i];
        fall_nxt[i]  = ~s2_p1[i];
      end else begin
        cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
      end
    end
    evt_n = popcount(rise_nxt | fall_nxt);
    // Clearing loads this edge's events so they are not lost.
    evt_nxt = CLR ? sat_add('0, evt_n) : sat_add(EVT_CNT, evt_n);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_p0   <= '0;
      s2_p1   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= '0;
      end
      CLEAN   <= '0;
      RISE    <= '0;
      FALL    <= '0;
      CHG     <= 1'b0;
      EVT_CNT <= '0;
    end else begin
      // stage p0/p1: two-flop synchronizer
      s1_p0 <= RAW_IN;
      s2_p1 <= s1_p0;
      // stage p2: debounce counters and registered outputs
      for (int i = 0; i < WIDTH; i++) begin
        cnt_p2[i] <= cnt_nxt[i];
      end
      CLEAN   <= clean_nxt;
      RISE    <= rise_nxt;
      FALL    <= fall_nxt;
      CHG     <= |(rise_nxt | fall_nxt);
      EVT_CNT <= evt_nxt;
    end
  end

endmodule

// File: tb/tb_in_conditioner.sv
module tb_in_conditioner;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw_in;
  logic       clr;

  logic [4:0] clean_a, rise_a, fall_a;
  logic       chg_a;
  logic [7:0] evt_a;
  logic [4:0] clean_b, rise_b, fall_b;
  logic       chg_b;
  logic [7:0] evt_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [4:0] clean;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       chg;
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];

  // Reference state, index 0 = DB_CYCLES 4 instance, index 1 = DB_CYCLES 1.
  int         dbv [2] = '{4, 1};
  logic [4:0] ms1 [2];
  logic [4:0] ms2 [2];
  logic [4:0] mcl [2];
  logic [4:0] hist [2][4];
  int         mevt [2];

  in_conditioner #(.WIDTH(5), .DB_CYCLES(4), .CNT_W(3), .EVT_W(8)) dut_a (
    .CLK(clk), .RST_N(rst_n), .RAW_IN(raw_in), .CLR(clr),
    .CLEAN(clean_a), .RISE(rise_a), .FALL(fall_a), .CHG(chg_a), .EVT_CNT(evt_a)
  );

  in_conditioner #(.WIDTH(5), .DB_CYCLES(1), .CNT_W(3), .EVT_W(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .RAW_IN(raw_in), .CLR(clr),
    .CLEAN(clean_b), .RISE(rise_b), .FALL(fall_b), .CHG(chg_b), .EVT_CNT(evt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      ms1[d] = '0; ms2[d] = '0; mcl[d] = '0; mevt[d] = 0;
      for (int k = 0; k < 4; k++) hist[d][k] = '0;
    end
  endtask

  // History-based reference: a channel flips when the last DB synchronized
  // samples (including the one seen at this edge) all differ from CLEAN.
  task automatic model_edge(input logic [4:0] raw, input logic c, input logic rstn);
    exp_t e;
    logic [4:0] r, f;
    logic flip;
    int n, s;
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        ms1[d] = '0; ms2[d] = '0; mcl[d] = '0; mevt[d] = 0;
        for (int k = 0; k < 4; k++) hist[d][k] = '0;
        r = '0; f = '0;
      end else begin
        for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = ms2[d];
        r = '0; f = '0;
        for (int i = 0; i < 5; i++) begin
          flip = 1'b1;
          for (int k = 0; k < dbv[d]; k++)
            if (hist[d][k][i] == mcl[d][i]) flip = 1'b0;
          r[i] = flip & ~mcl[d][i];
          f[i] = flip & mcl[d][i];
        end
        mcl[d] = mcl[d] ^ (r | f);
        n = $countones(r | f);
        s = c ? n : mevt[d] + n;
        mevt[d] = (s > 255) ? 255 : s;
        ms2[d] = ms1[d];
        ms1[d] = raw;
      end
      e.clean = mcl[d]; e.rise = r; e.fall = f; e.chg = |(r | f);
      e.evt = 8'(mevt[d]);
      sb.push_back(e);
    end
  endtask

  task automatic step(input logic [4:0] raw, input logic c, input logic rstn);
    exp_t e;
    @(negedge clk);
    raw_in = raw;
    clr    = c;
    rst_n  = rstn;
    model_edge(raw, c, rstn);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        if (d == 0) begin
          check("A.clean", 32'(clean_a), 32'(e.clean));
          check("A.rise",  32'(rise_a),  32'(e.rise));
          check("A.fall",  32'(fall_a),  32'(e.fall));
          check("A.chg",   32'(chg_a),   32'(e.chg));
          check("A.evt",   32'(evt_a),   32'(e.evt));
        end else begin
          check("B.clean", 32'(clean_b), 32'(e.clean));
          check("B.rise",  32'(rise_b),  32'(e.rise));
          check("B.fall",  32'(fall_b),  32'(e.fall));
          check("B.chg",   32'(chg_b),   32'(e.chg));
          check("B.evt",   32'(evt_b),   32'(e.evt));
        end
      end
    end
  endtask

  task automatic hold(input logic [4:0] raw, input int n);
    for (int j = 0; j < n; j++) step(raw, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n  = 1'b0;
    raw_in = '0;
    clr    = 1'b0;
    model_clear();

    // Reset state
    step(5'b00000, 1'b0, 1'b0);
    step(5'b00001, 1'b0, 1'b0);
    check("rst_clean", 32'(clean_a), 32'd0);
    check("rst_evt",   32'(evt_a),   32'd0);

    // Single rise on channel 0, raw held from edge 0
    for (int j = 0; j < 8; j++) begin
      step(5'b00001, 1'b0, 1'b1);
      if (j == 4) check("s1_clean_early", 32'(clean_a), 32'd0);
      if (j == 5) begin
        check("s1_clean", 32'(clean_a), 32'b00001);
        check("s1_rise",  32'(rise_a),  32'b00001);
        check("s1_chg",   32'(chg_a),   32'd1);
        check("s1_evt",   32'(evt_a),   32'd1);
      end
      if (j == 6) check("s1_rise_once", 32'(rise_a), 32'd0);
    end

    // Glitch rejection: 3-cycle pulse on channel 2
    hold(5'b00101, 3);
    hold(5'b00001, 8);
    check("gl3_clean", 32'(clean_a), 32'b00001);
    check("gl3_evt",   32'(evt_a),   32'd1);
    // 4-cycle pulse is accepted and then released
    hold(5'b00101, 4);
    hold(5'b00001, 10);
    check("gl4_clean", 32'(clean_a), 32'b00001);
    check("gl4_evt",   32'(evt_a),   32'd3);

    // Simultaneous events
    hold(5'b00000, 8);
    check("sim0_evt", 32'(evt_a), 32'd4);
    hold(5'b11111, 8);
    check("sim1_clean", 32'(clean_a), 32'b11111);
    check("sim1_evt",   32'(evt_a),   32'd9);
    hold(5'b01010, 8);
    check("sim2_clean", 32'(clean_a), 32'b01010);
    check("sim2_evt",   32'(evt_a),   32'd12);
    hold(5'b00000, 8);
    check("sim3_evt", 32'(evt_a), 32'd14);

    // Toggle stress on channel 4
    for (int j = 0; j < 50; j++) step((j % 2 == 0) ? 5'b10000 : 5'b00000, 1'b0, 1'b1);
    hold(5'b00000, 4);
    check("tog_clean", 32'(clean_a), 32'd0);
    check("tog_evt",   32'(evt_a),   32'd14);

    // Reset mid-debounce with channel 1 held high
    hold(5'b00010, 3);
    step(5'b00010, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0);
    check("mrst_clean", 32'(clean_a), 32'd0);
    for (int j = 0; j < 8; j++) begin
      step(5'b00010, 1'b0, 1'b1);
      if (j == 4) check("mrst_clean_early", 32'(clean_a), 32'd0);
      if (j == 5) check("mrst_clean_rise",  32'(clean_a), 32'b00010);
    end

    // Clear on a quiet cycle, then drive toward saturation
    step(5'b00010, 1'b1, 1'b1);
    check("clr_quiet", 32'(evt_a), 32'd0);
    hold(5'b00000, 8);
    for (int j = 0; j < 25; j++) begin
      hold(5'b11111, 8);
      hold(5'b00000, 8);
    end
    hold(5'b00011, 8);
    hold(5'b00001, 8);
    check("sat_254", 32'(evt_a), 32'd254);
    hold(5'b01111, 8);
    check("sat_255", 32'(evt_a), 32'd255);
    hold(5'b01111, 4);
    check("sat_hold", 32'(evt_a), 32'd255);

    // Clear on the cycle where two falls are accepted (edge 5 after the change)
    for (int j = 0; j < 8; j++) begin
      step(5'b01100, (j == 5) ? 1'b1 : 1'b0, 1'b1);
      if (j == 5) check("clr_evt2", 32'(evt_a), 32'd2);
    end
    step(5'b01100, 1'b1, 1'b1);
    check("clr_evt0", 32'(evt_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
